sdram_frame_read_ctrl: RTL and testbench

- Sequences Avalon-MM burst reads of one video frame from SDRAM into the frame CDC FIFO, on the SDRAM side.
- Issues bursts only when FIFO credit covers the new burst plus all words still in flight, so readdatavalid data is never dropped.
- Walks the frame linearly from FRAME_BASE, shortens the last burst, waits for in-flight data to drain, then pulses frame_done_o and rearms.

---
 rtl/sdram_frame_read_ctrl.sv | 130 +++++++++++++
 tb/tb_sdram_frame_read_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_frame_read_ctrl.sv
// Reads one video frame from SDRAM as Avalon-MM bursts into the frame FIFO.
// Bursts are issued only when FIFO credit covers the new burst plus all words still in flight.
`timescale 1ns/1ps
module sdram_frame_read_ctrl #(
  parameter int ADDR_W      = 27,
  parameter int BURST_LEN   = 8,
  parameter int FIFO_DEPTH  = 256,
  parameter int FRAME_BASE  = 0,
  parameter int FRAME_WORDS = 259200
) (
  input  logic              sdram_clk,
  input  logic              rst_n,
  input  logic              frame_ready_i,
  input  logic              stop_i,
  input  logic [8:0]        fifo_wrusedw_i,
  output logic [ADDR_W-1:0] sdram_address_o,
  output logic [7:0]        sdram_burstcount_o,
  output logic              sdram_read_o,
  input  logic              sdram_waitrequest_i,
  input  logic              sdram_readdatavalid_i,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic [8:0]        outstanding_o
);

  typedef enum logic [2:0] {ST_IDLE, ST_CHECK, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

  localparam logic [ADDR_W-1:0] BASE_C     = ADDR_W'(FRAME_BASE);
  localparam logic [ADDR_W-1:0] WORDS_C    = ADDR_W'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] BLEN_MAX_C = ADDR_W'(BURST_LEN);
  localparam logic [7:0]        BLEN_C     = 8'(BURST_LEN);
  localparam logic [9:0]        DEPTH_C    = 10'(FIFO_DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        bcount_q, bcount_d;
  logic              read_q, read_d;
  logic [8:0]        outst_q, outst_d;
  logic              stop_q, stop_d;

  logic [7:0] blen;
  logic       stop_seen;
  logic       accept;
  logic       credit_ok;
  logic       rdv_eff;

  // Compare at full address width so a large remaining count cannot alias into 8 bits.
  assign blen      = (remaining_q < BLEN_MAX_C) ? remaining_q[7:0] : BLEN_C;
  assign stop_seen = stop_q | stop_i;
  assign accept    = read_q & ~sdram_waitrequest_i;
  assign credit_ok = ({1'b0, fifo_wrusedw_i} + {1'b0, outst_q} + {2'b00, blen}) <= DEPTH_C;
  assign rdv_eff   = sdram_readdatavalid_i & (outst_q != 9'd0);
  assign outst_d   = outst_q + (accept ? {1'b0, bcount_q} : 9'd0) - {8'd0, rdv_eff};

  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    bcount_d    = bcount_q;
    read_d      = read_q;
    stop_d      = (state_q == ST_IDLE) ? 1'b0 : stop_seen;
    case (state_q)
      ST_IDLE: begin
        next_addr_d = BASE_C;
        remaining_d = WORDS_C;
        if (frame_ready_i) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (stop_seen || remaining_q == '0) begin
          state_d = ST_DRAIN;
        end else if (credit_ok) begin
          addr_d   = next_addr_q;
          bcount_d = blen;
          read_d   = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Request stays up until accepted; a stop here is only honoured back in CHECK.
        if (accept) begin
          read_d      = 1'b0;
          next_addr_d = next_addr_q + ADDR_W'(bcount_q);
          remaining_d = remaining_q - ADDR_W'(bcount_q);
          state_d     = ST_CHECK;
        end
      end
      ST_DRAIN: begin
        if (outst_q == 9'd0) state_d = ST_DONE;
      end
      ST_DONE: begin
        stop_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sdram_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      next_addr_q <= BASE_C;
      remaining_q <= WORDS_C;
      addr_q      <= BASE_C;
      bcount_q    <= 8'd0;
      read_q      <= 1'b0;
      outst_q     <= 9'd0;
      stop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      bcount_q    <= bcount_d;
      read_q      <= read_d;
      outst_q     <= outst_d;
      stop_q      <= stop_d;
    end
  end

  assign sdram_address_o    = addr_q;
  assign sdram_burstcount_o = bcount_q;
  assign sdram_read_o       = read_q;
  assign busy_o             = (state_q != ST_IDLE);
  assign frame_done_o       = (state_q == ST_DONE);
  assign outstanding_o      = outst_q;

endmodule

// File: tb/tb_sdram_frame_read_ctrl.sv
// Bench for sdram_frame_read_ctrl: table-driven frames plus random frames against an
// SDRAM/FIFO reference model, and hand-written sequences for stall, net-change and reset cases.
`timescale 1ns/1ps
module tb_sdram_frame_read_ctrl;
  localparam int AW      = 27;
  localparam int BL      = 8;
  localparam int DEPTH   = 256;
  localparam int FW      = 20;
  localparam int BASE    = 0;
  localparam int S_DEPTH = 16;
  localparam int S_BASE  = 5;
  localparam int NBURSTS = (FW + BL - 1) / BL;

  typedef struct {
    int lat;
    int wait_pct;
    int hold;
    int stop_burst;
    int fill;
    int drain_pct;
    int exp_bursts;
    int exp_words;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, frame_ready, stop, wait_r, rdv;
  logic [8:0]    wrusedw;
  logic [AW-1:0] addr;
  logic [7:0]    bcnt;
  logic          rd, busy, done;
  logic [8:0]    outst;

  logic          s_frame_ready, s_stop, s_wait, s_rdv;
  logic [8:0]    s_wrusedw;
  logic [AW-1:0] s_addr;
  logic [7:0]    s_bcnt;
  logic          s_rd, s_busy, s_done;
  logic [8:0]    s_outst;

  sdram_frame_read_ctrl #(.ADDR_W(AW), .BURST_LEN(BL), .FIFO_DEPTH(DEPTH),
                          .FRAME_BASE(BASE), .FRAME_WORDS(FW)) dut (
    .sdram_clk(clk), .rst_n(rst_n), .frame_ready_i(frame_ready), .stop_i(stop),
    .fifo_wrusedw_i(wrusedw), .sdram_address_o(addr), .sdram_burstcount_o(bcnt),
    .sdram_read_o(rd), .sdram_waitrequest_i(wait_r), .sdram_readdatavalid_i(rdv),
    .busy_o(busy), .frame_done_o(done), .outstanding_o(outst));

  sdram_frame_read_ctrl #(.ADDR_W(AW), .BURST_LEN(BL), .FIFO_DEPTH(S_DEPTH),
                          .FRAME_BASE(S_BASE), .FRAME_WORDS(FW)) dut_small (
    .sdram_clk(clk), .rst_n(rst_n), .frame_ready_i(s_frame_ready), .stop_i(s_stop),
    .fifo_wrusedw_i(s_wrusedw), .sdram_address_o(s_addr), .sdram_burstcount_o(s_bcnt),
    .sdram_read_o(s_rd), .sdram_waitrequest_i(s_wait), .sdram_readdatavalid_i(s_rdv),
    .busy_o(s_busy), .frame_done_o(s_done), .outstanding_o(s_outst));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pend_q[$];
  int model_out, fifo_level, n_acc, n_words, n_done, exp_rem, hold_left;
  logic [AW-1:0] exp_addr;
  bit stop_sent;
  int cfg_lat = 3, cfg_wait = 0, cfg_sb = -1, cfg_drain = 50;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample pre-edge bus state, advance, then update the SDRAM/FIFO model and check.
  task automatic step();
    logic          pr_read, pr_wait, pr_rdv;
    logic [AW-1:0] pr_addr;
    logic [7:0]    pr_cnt;
    int            pr_wr, pr_out, want;
    pr_read = rd; pr_wait = wait_r; pr_rdv = rdv;
    pr_addr = addr; pr_cnt = bcnt; pr_wr = int'(wrusedw); pr_out = model_out;
    @(posedge clk); #1;
    cyc++;
    if (pr_read && pr_wait) begin
      chk("hold_read", rd, 1);
      chk("hold_addr", addr, pr_addr);
      chk("hold_count", bcnt, pr_cnt);
    end
    if (!pr_read && rd) begin
      chk("credit_at_issue", (pr_wr + pr_out + int'(bcnt)) <= DEPTH, 1);
      chk("issue_after_stop", stop_sent, 0);
    end
    if (rd) chk("count_nonzero", bcnt != 8'd0, 1);
    if (pr_rdv) begin
      if (pend_q.size() == 0) chk("spurious_rdv", 1, 0);
      else begin
        void'(pend_q.pop_front());
        model_out--; fifo_level++; n_words++;
      end
    end
    if (pr_read && !pr_wait) begin
      want = (exp_rem < BL) ? exp_rem : BL;
      chk("burst_addr", pr_addr, exp_addr);
      chk("burst_count", pr_cnt, want);
      exp_addr = exp_addr + AW'(want);
      exp_rem -= want;
      n_acc++;
      model_out += int'(pr_cnt);
      for (int i = 0; i < int'(pr_cnt); i++) pend_q.push_back(cyc + cfg_lat);
    end
    chk("outstanding", outst, model_out);
    chk("fifo_overflow", (fifo_level + model_out) <= DEPTH, 1);
    if (done) n_done++;
    if (fifo_level > 0 && $urandom_range(0, 99) < cfg_drain) fifo_level--;
  endtask

  task automatic drive_auto();
    wait_r = ($urandom_range(0, 99) < cfg_wait);
    if (rd && n_acc == 1 && hold_left > 0) begin
      wait_r = 1'b1;
      hold_left--;
    end
    stop = 1'b0;
    if (cfg_sb >= 0 && !stop_sent && rd && n_acc == cfg_sb) begin
      stop = 1'b1;
      stop_sent = 1'b1;
    end
    rdv = (pend_q.size() > 0) && (pend_q[0] <= cyc + 1);
    wrusedw = 9'(fifo_level);
  endtask

  task automatic start_frame(input vec_t v);
    cfg_lat = v.lat; cfg_wait = v.wait_pct; cfg_sb = v.stop_burst; cfg_drain = v.drain_pct;
    hold_left = v.hold; fifo_level = v.fill;
    exp_addr = AW'(BASE); exp_rem = FW;
    n_acc = 0; n_words = 0; n_done = 0; stop_sent = 1'b0;
  endtask

  task automatic run_to_done(input string tag, input int exp_bursts, input int exp_words);
    int guard = 0;
    int start = cyc;
    do begin
      drive_auto();
      step();
      if (busy) frame_ready = 1'b0;
      guard++;
    end while (n_done == 0 && guard < 3000);
    chk({tag, "_done_seen"}, n_done, 1);
    chk({tag, "_words_at_done"}, n_words, exp_words);
    chk({tag, "_bursts"}, n_acc, exp_bursts);
    repeat (3) begin
      drive_auto();
      step();
    end
    chk({tag, "_done_once"}, n_done, 1);
    chk({tag, "_idle_after"}, busy, 0);
    $display("frame %s: bursts=%0d words=%0d cycles=%0d", tag, n_acc, n_words, cyc - start);
  endtask

  vec_t tbl[6];
  vec_t v;
  int   nb, nw, cnt;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{3, 0,  0, -1, 0,   50, 3, 20};  // plain frame, bursts 8/8/4
    tbl[1] = '{3, 0,  5, -1, 0,   50, 3, 20};  // second burst stalled 5 cycles
    tbl[2] = '{2, 0,  0,  1, 0,   50, 2, 16};  // stop during second burst
    tbl[3] = '{4, 30, 0,  0, 0,   50, 1, 8};
    tbl[4] = '{1, 20, 2,  2, 0,   50, 3, 20};
    tbl[5] = '{5, 10, 0, -1, 245, 30, 3, 20};  // nearly full FIFO throttles issue

    rst_n = 1'b0; frame_ready = 1'b0; stop = 1'b0; wait_r = 1'b0; rdv = 1'b0; wrusedw = '0;
    s_frame_ready = 1'b0; s_stop = 1'b0; s_wait = 1'b0; s_rdv = 1'b0; s_wrusedw = '0;
    model_out = 0; fifo_level = 0; exp_addr = AW'(BASE); exp_rem = FW;
    #23;
    chk("rst_read", rd, 0);
    chk("rst_addr", addr, BASE);
    chk("rst_count", bcnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_outst", outst, 0);
    chk("rst_small_addr", s_addr, S_BASE);
    @(negedge clk); rst_n = 1'b1;

    // readdatavalid with nothing outstanding must not underflow the counter
    rdv = 1'b1;
    @(posedge clk); #1;
    chk("no_underflow", outst, 0);
    rdv = 1'b0;

    for (int r = 0; r < 6; r++) begin
      start_frame(tbl[r]);
      frame_ready = 1'b1;
      run_to_done($sformatf("table%0d", r), tbl[r].exp_bursts, tbl[r].exp_words);
    end

    for (int k = 0; k < 8; k++) begin
      v.lat = $urandom_range(1, 6);
      v.wait_pct = $urandom_range(0, 50);
      v.hold = $urandom_range(0, 3);
      v.stop_burst = $urandom_range(0, 4) - 1;
      v.fill = $urandom_range(0, 250);
      v.drain_pct = $urandom_range(10, 90);
      nb = (v.stop_burst < 0 || v.stop_burst >= NBURSTS) ? NBURSTS : v.stop_burst + 1;
      nw = (nb * BL < FW) ? nb * BL : FW;
      v.exp_bursts = nb; v.exp_words = nw;
      start_frame(v);
      frame_ready = 1'b1;
      run_to_done($sformatf("random%0d", k), nb, nw);
    end

    // Small FIFO: 10 used + 8 > 16 blocks issue; at 8 used the next CHECK issues.
    wait_r = 1'b0; rdv = 1'b0; stop = 1'b0;
    s_wrusedw = 9'd10; s_frame_ready = 1'b1;
    cnt = 0;
    repeat (8) begin
      step();
      if (s_rd) cnt++;
    end
    chk("small_blocked_reads", cnt, 0);
    chk("small_busy", s_busy, 1);
    s_wrusedw = 9'd8;
    step();
    chk("small_issue_read", s_rd, 1);
    chk("small_issue_addr", s_addr, S_BASE);
    chk("small_issue_count", s_bcnt, 8);
    s_frame_ready = 1'b0;
    $display("credit: blocked_reads=%0d issued=%0b addr=%0d count=%0d", cnt, s_rd, s_addr, s_bcnt);

    // Accept and readdatavalid in the same cycle with 3 outstanding and an 8-word burst.
    start_frame(tbl[0]);
    wait_r = 1'b0; rdv = 1'b0; stop = 1'b0; wrusedw = '0; frame_ready = 1'b1;
    for (int i = 0; i < 10 && !rd; i++) step();
    chk("net_first_issue", rd, 1);
    frame_ready = 1'b0;
    step();
    chk("net_out_first", outst, 8);
    wait_r = 1'b1; rdv = 1'b1;
    repeat (5) step();
    chk("net_out_held", outst, 3);
    chk("net_second_pending", rd, 1);
    wait_r = 1'b0;
    step();
    chk("net_change", outst, 10);
    $display("net change: outstanding=%0d", outst);
    rdv = 1'b0;
    run_to_done("same_cycle", 3, 20);

    // Asynchronous reset in DRAIN with 5 words outstanding.
    v = tbl[0]; v.lat = 40;
    start_frame(v);
    wait_r = 1'b0; rdv = 1'b0; stop = 1'b0; wrusedw = '0; frame_ready = 1'b1;
    for (int i = 0; i < 10 && !rd; i++) step();
    frame_ready = 1'b0; stop = 1'b1; stop_sent = 1'b1;
    step();
    stop = 1'b0;
    step();
    rdv = 1'b1;
    repeat (3) step();
    rdv = 1'b0;
    chk("drain_out", outst, 5);
    chk("drain_busy", busy, 1);
    chk("drain_read", rd, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_read", rd, 0);
    chk("async_rst_addr", addr, BASE);
    chk("async_rst_count", bcnt, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_outst", outst, 0);
    $display("async reset: busy=%0b outstanding=%0d", busy, outst);
    pend_q.delete(); model_out = 0; fifo_level = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    start_frame(tbl[0]);
    frame_ready = 1'b1;
    run_to_done("after_reset", 3, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
